scope_trigger_capture: RTL and testbench

SCOPE_TRIGGER_CAPTURE -- requirements
Module: scope_trigger_capture

---
 rtl/scope_trigger_capture_if.sv | 14 +
 rtl/scope_trigger_capture.sv | 133 +++++++++++++
 tb/tb_scope_trigger_capture.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/scope_trigger_capture_if.sv
// Sample stream into the capture block and the display read port out of its buffer.
// The master side feeds samples and read addresses; the slave side is the capture block.
interface scope_trigger_capture_if #(
  parameter int width  = 12,
  parameter int ADDR_W = 8
) ();
  logic signed [width-1:0]  sample_in;
  logic                     sample_valid;
  logic        [ADDR_W-1:0] rd_addr;
  logic signed [width-1:0]  rd_data;

  modport master (output sample_in, sample_valid, rd_addr, input rd_data);
  modport slave  (input sample_in, sample_valid, rd_addr, output rd_data);
endinterface

// File: rtl/scope_trigger_capture.sv
// Oscilloscope trigger and capture: decimates the sample stream, waits for a level
// crossing (or a timeout), then fills a DEPTH-word buffer that the display reads out.
module scope_trigger_capture #(
  parameter int width   = 12,
  parameter int DEPTH   = 256,
  parameter int DECIM_W = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clock,
  input  logic                      resetn,
  scope_trigger_capture_if.slave    bus,
  input  logic        [DECIM_W-1:0] decim,
  input  logic signed [width-1:0]   trig_level,
  input  logic                      trig_slope,
  input  logic                      arm,
  input  logic                      auto_rearm,
  input  logic                      frame_lock,
  output logic                      capture_done,
  output logic                      triggered,
  output logic        [1:0]         state_o
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    CAPTURE = 2'b10,
    DONE    = 2'b11
  } state_t;

  state_t                   state;
  logic [DECIM_W-1:0]       decim_cnt;
  logic [DECIM_W-1:0]       decim_reload;
  logic [TO_W-1:0]          to_cnt;
  logic [ADDR_W-1:0]        wr_ptr;
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [width-1:0]  prev;
  logic                     prev_ok;
  logic                     strobe;
  logic                     trig_hit;
  logic                     timeout_hit;
  logic                     wr_en;
  logic signed [width-1:0]  mem [DEPTH];

  // NOTE: every signal of this block is assigned on every path, so no latch is inferred.
  always_comb begin
    decim_reload = (decim == '0) ? '0 : decim - 1'b1;
    strobe       = bus.sample_valid && (decim_cnt == '0);
    if (trig_slope)
      trig_hit = prev_ok && (prev < trig_level) && (bus.sample_in >= trig_level);
    else
      trig_hit = prev_ok && (prev > trig_level) && (bus.sample_in <= trig_level);
    timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));
    wr_en       = strobe && (((state == ARMED) && (trig_hit || timeout_hit)) ||
                             (state == CAPTURE));
    wr_addr     = (state == CAPTURE) ? wr_ptr : '0;
  end

  // NOTE: the buffer has no reset so it can map onto block RAM; only its read register is reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= bus.sample_in;
  end

  // Non-blocking read: a same-address write in this cycle is seen only on the next read.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) bus.rd_data <= '0;
    else         bus.rd_data <= mem[bus.rd_addr];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      decim_cnt    <= '0;
      to_cnt       <= '0;
      wr_ptr       <= '0;
      prev         <= '0;
      prev_ok      <= 1'b0;
      capture_done <= 1'b0;
      triggered    <= 1'b0;
    end else begin
      if (bus.sample_valid)
        decim_cnt <= (decim_cnt == '0) ? decim_reload : decim_cnt - 1'b1;
      if (strobe) begin
        prev    <= bus.sample_in;
        prev_ok <= 1'b1;
      end
      // NOTE: non-blocking throughout; the re-arm assignments below override the updates above.
      unique case (state)
        IDLE: begin
          if (arm) begin
            state     <= ARMED;
            decim_cnt <= decim_reload;
            to_cnt    <= '0;
            prev_ok   <= 1'b0;
          end
        end
        ARMED: begin
          if (strobe) begin
            if (trig_hit || timeout_hit) begin
              state     <= CAPTURE;
              wr_ptr    <= ADDR_W'(1);
              triggered <= trig_hit;
              to_cnt    <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (strobe) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == ADDR_W'(DEPTH - 1)) begin
              state        <= DONE;
              capture_done <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!frame_lock && (auto_rearm || arm)) begin
            state        <= ARMED;
            capture_done <= 1'b0;
            decim_cnt    <= decim_reload;
            to_cnt       <= '0;
            prev_ok      <= 1'b0;
          end
        end
      endcase
    end
  end

  assign state_o = state;
endmodule

// File: tb/tb_scope_trigger_capture.sv
// Bench for scope_trigger_capture: expected buffer words are queued as stimulus is
// driven and compared when the display read port returns them.
module tb_scope_trigger_capture;
  localparam int W      = 12;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam logic [1:0] S_IDLE = 2'b00, S_ARMED = 2'b01, S_CAPT = 2'b10, S_DONE = 2'b11;

  logic                clock = 1'b0;
  logic                resetn;
  logic [15:0]         decim;
  logic signed [W-1:0] trig_level;
  logic                trig_slope, arm, auto_rearm, frame_lock;
  logic                capture_done, triggered;
  logic [1:0]          state_o;

  int n_vectors     = 0;
  int n_miscompares = 0;
  int exp_q[$];
  int rb[0:DEPTH-1];
  int sine_tab[0:511];

  scope_trigger_capture_if #(.width(W), .ADDR_W(ADDR_W)) bus ();

  scope_trigger_capture #(.width(W), .DEPTH(DEPTH), .DECIM_W(16), .TIMEOUT(1024)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .bus         (bus),
    .decim       (decim),
    .trig_level  (trig_level),
    .trig_slope  (trig_slope),
    .arm         (arm),
    .auto_rearm  (auto_rearm),
    .frame_lock  (frame_lock),
    .capture_done(capture_done),
    .triggered   (triggered),
    .state_o     (state_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic step(input int v, input logic valid);
    bus.sample_in    = W'(v);
    bus.sample_valid = valid;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step(0, 1'b0);
    arm = 1'b0;
  endtask

  task automatic read_back(input string name);
    int e;
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_addr = ADDR_W'(a);
      step(0, 1'b0);
      rb[a] = int'(bus.rd_data);
      if (exp_q.size() == 0) begin
        check({name, "_sb_underflow"}, 0, 1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_mem[%0d]", name, a), bus.rd_data, e);
      end
    end
    check({name, "_sb_leftover"}, exp_q.size(), 0);
    exp_q.delete();
    bus.rd_addr = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    resetn = 1'b0; decim = 16'd1; trig_level = '0; trig_slope = 1'b1;
    arm = 1'b0; auto_rearm = 1'b0; frame_lock = 1'b0;
    bus.sample_in = '0; bus.sample_valid = 1'b0; bus.rd_addr = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_state", state_o, S_IDLE);
    check("rst_done", capture_done, 0);
    check("rst_trig", triggered, 0);
    check("rst_rd_data", bus.rd_data, 0);
    resetn = 1'b1;
    step(0, 1'b0);

    // IDLE ignores a level crossing without arm
    for (int v = -3; v <= 3; v++) step(v, 1'b1);
    check("idle_ignores", state_o, S_IDLE);

    // Rising ramp, decim=1, level 0
    pulse_arm();
    check("ramp_armed", state_o, S_ARMED);
    for (int v = -100; v <= 255; v++) begin
      if (v >= 0) exp_q.push_back(v);
      step(v, 1'b1);
      if (v == -1)  check("ramp_pre_trig", state_o, S_ARMED);
      if (v == 0)   check("ramp_capture", state_o, S_CAPT);
      if (v == 0)   check("ramp_triggered", triggered, 1);
      if (v == 254) check("ramp_done_early", capture_done, 0);
    end
    check("ramp_done", capture_done, 1);
    check("ramp_state_done", state_o, S_DONE);
    read_back("ramp");

    // Constant 50, decim=4: forced capture on the 1024th strobe
    decim = 16'd4;
    pulse_arm();
    check("to_armed", state_o, S_ARMED);
    check("to_done_clr", capture_done, 0);
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(50);
    for (int i = 1; i <= 4096; i++) begin
      step(50, 1'b1);
      if (i == 4095) check("to_pre_force", state_o, S_ARMED);
    end
    check("to_capture", state_o, S_CAPT);
    check("to_triggered", triggered, 0);
    for (int j = 1; j <= 1020; j++) begin
      step(50, 1'b1);
      if (j == 1019) check("to_done_early", capture_done, 0);
    end
    check("to_done", capture_done, 1);
    check("to_state_done", state_o, S_DONE);
    read_back("timeout");

    // Falling slope on a full-scale sine, decim=0 behaving as decim=1
    for (int i = 0; i < 512; i++)
      sine_tab[i] = $rtoi(2047.0 * $sin(2.0 * 3.14159265358979 * i / 64.0));
    n = -1;
    for (int i = 1; i < 256; i++)
      if (n < 0 && sine_tab[i-1] > 0 && sine_tab[i] <= 0) n = i;
    decim = 16'd0; trig_slope = 1'b0;
    pulse_arm();
    for (int i = 0; i <= n + DEPTH - 1; i++) begin
      if (i >= n) exp_q.push_back(sine_tab[i]);
      step(sine_tab[i], 1'b1);
    end
    check("fall_done", capture_done, 1);
    check("fall_triggered", triggered, 1);
    read_back("fall");
    check("fall_mem0_le0", rb[0] <= 0, 1);
    check("fall_mem1_lt_mem0", rb[1] < rb[0], 1);

    // frame_lock holds DONE even with auto_rearm
    frame_lock = 1'b1; auto_rearm = 1'b1;
    for (int c = 0; c < 500; c++) begin
      step(0, 1'b0);
      check("lock_hold", state_o, S_DONE);
    end
    frame_lock = 1'b0;
    step(0, 1'b0);
    check("lock_release_armed", state_o, S_ARMED);
    check("lock_release_done", capture_done, 0);

    // Reset in the middle of a capture, then restart from address 0
    auto_rearm = 1'b0; trig_slope = 1'b1; trig_level = '0;
    for (int v = -5; v <= 99; v++) step(v, 1'b1);
    check("abort_capturing", state_o, S_CAPT);
    #3 resetn = 1'b0;
    #1;
    check("abort_state", state_o, S_IDLE);
    check("abort_done", capture_done, 0);
    check("abort_trig", triggered, 0);
    check("abort_rd_data", bus.rd_data, 0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    step(0, 1'b0);
    check("abort_idle", state_o, S_IDLE);

    trig_level = 12'sd500;
    pulse_arm();
    for (int v = 490; v <= 755; v++) begin
      if (v >= 500) exp_q.push_back(v);
      if (v == 550) bus.rd_addr = 8'd50;
      step(v, 1'b1);
      if (v == 499) check("restart_pre_trig", state_o, S_ARMED);
      if (v == 500) check("restart_capture", state_o, S_CAPT);
      if (v == 550) check("rdw_old_word", bus.rd_data, 50);
      if (v == 551) check("rdw_new_word", bus.rd_data, 550);
    end
    check("restart_done", capture_done, 1);
    check("restart_triggered", triggered, 1);
    read_back("restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end
endmodule
